// File: rtl/csi_rx_pkg.sv
// Shared types and constants for the CSI-2 receive lane path.
package csi_rx_pkg;

  localparam int NUM_LANE_MAX = 4;
  localparam int BYTE_W       = 8;

  typedef enum logic {
    SYNC   = 1'b0,
    STREAM = 1'b1
  } deskew_state_e;

  // Only 1, 2 or 4 lanes are meaningful, and never more than are built.
  function automatic logic lane_count_legal(input logic [2:0] cnt, input int num_lane);
    return ((cnt == 3'd1) || (cnt == 3'd2) || (cnt == 3'd4)) && (int'(cnt) <= num_lane);
  endfunction

endpackage

// File: rtl/csi_rx_skew_fifo.sv
// Per-lane byte FIFO absorbing inter-lane skew; flush overrides push and pop.
module csi_rx_skew_fifo
  import csi_rx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = BYTE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/csi_rx_lane_deskew.sv
// N-lane deskew and word assembler: hunts for all lanes' first byte in SYNC,
// then pops one byte per active lane per cycle in STREAM.
module csi_rx_lane_deskew
  import csi_rx_pkg::*;
#(
  parameter int NUM_LANE   = 2,
  parameter int MAX_SKEW   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         byte_clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [2:0]                   active_lanes,
  input  logic [BYTE_W*NUM_LANE-1:0]   byte_in,
  input  logic [NUM_LANE-1:0]          byte_vld,
  input  logic                         packet_done,
  output logic                         wait_for_sync,
  output logic                         packet_done_out,
  output logic [BYTE_W*NUM_LANE-1:0]   word_out,
  output logic                         word_vld,
  output logic                         skew_err,
  output logic [7:0]                   err_cnt,
  output deskew_state_e                state_dbg
);

  localparam int SKEW_W = 4;

  // byte_vld and word_vld are valid-only qualifiers: there is no ready, the
  // aligners never stall and the packet handler must accept every word.
  deskew_state_e       state, state_next;
  logic [NUM_LANE-1:0] live_mask, mask, mask_q;
  logic [NUM_LANE-1:0] push, seen, arrived, arrived_n, full, empty;
  logic [SKEW_W-1:0]   timer, timer_n;
  logic [2:0]          live_cnt;
  logic                all_arrived, timeout, overflow, pop_all, flush, err;
  logic [BYTE_W-1:0]   lane_dout [NUM_LANE];
  logic [BYTE_W*NUM_LANE-1:0] popped;

  always_comb begin
    live_cnt = lane_count_legal(active_lanes, NUM_LANE) ? active_lanes : 3'd1;
    for (int i = 0; i < NUM_LANE; i++) live_mask[i] = (i < int'(live_cnt));
  end

  // The lane count is only followed while hunting; STREAM keeps the latched one.
  assign mask        = (state == SYNC) ? live_mask : mask_q;
  assign push        = byte_vld & mask;
  assign seen        = (arrived | push) & mask;
  assign all_arrived = (seen == mask);
  assign timeout     = (timer == SKEW_W'(MAX_SKEW));
  assign overflow    = (state == STREAM) && |(push & full);
  assign pop_all     = enable && (state == STREAM) && ((~empty & mask) == mask);

  always_comb begin
    popped = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      if (mask[i]) popped[i*BYTE_W +: BYTE_W] = lane_dout[i];
    end
  end

  always_comb begin
    state_next = state;
    arrived_n  = arrived;
    timer_n    = timer;
    flush      = 1'b0;
    err        = 1'b0;
    if (!enable) begin
      state_next = SYNC;
      flush      = 1'b1;
      arrived_n  = '0;
      timer_n    = '0;
    end else begin
      case (state)
        SYNC: begin
          // The last arrival beats a timeout landing in the same cycle.
          if (all_arrived) begin
            state_next = STREAM;
            arrived_n  = '0;
            timer_n    = '0;
          end else if (timeout) begin
            err       = 1'b1;
            flush     = 1'b1;
            arrived_n = '0;
            timer_n   = '0;
          end else begin
            arrived_n = seen;
            if (|seen) timer_n = timer + SKEW_W'(1);
          end
        end
        STREAM: begin
          if (overflow || packet_done) begin
            state_next = SYNC;
            flush      = 1'b1;
            err        = overflow;
          end
        end
        default: state_next = SYNC;
      endcase
    end
  end

  always_ff @(posedge byte_clock or posedge reset) begin
    if (reset) state <= SYNC;
    else       state <= state_next;
  end

  always_ff @(posedge byte_clock or posedge reset) begin
    if (reset) begin
      mask_q          <= NUM_LANE'(1);
      arrived         <= '0;
      timer           <= '0;
      word_out        <= '0;
      word_vld        <= 1'b0;
      packet_done_out <= 1'b0;
      skew_err        <= 1'b0;
      err_cnt         <= '0;
    end else begin
      mask_q          <= mask;
      arrived         <= arrived_n;
      timer           <= timer_n;
      word_vld        <= pop_all;
      packet_done_out <= packet_done && enable;
      skew_err        <= err;
      if (pop_all) word_out <= popped;
      if (err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign wait_for_sync = (state == SYNC);
  assign state_dbg     = state;

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    csi_rx_skew_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (BYTE_W)
    ) u_fifo (
      .clk   (byte_clock),
      .rst   (reset),
      .push  (push[g]),
      .pop   (pop_all && mask[g]),
      .flush (flush),
      .din   (byte_in[g*BYTE_W +: BYTE_W]),
      .dout  (lane_dout[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

endmodule

// File: tb/tb_csi_rx_lane_deskew.sv
// Randomised bench for csi_rx_lane_deskew against a queue-based lane model.
module tb_csi_rx_lane_deskew;
  import csi_rx_pkg::*;

  localparam int NL = 4;
  localparam int MS = 4;
  localparam int FD = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          byte_clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [2:0]    active_lanes;
  logic [8*NL-1:0] byte_in;
  logic [NL-1:0] byte_vld;
  logic          packet_done;
  logic          wait_for_sync, packet_done_out, word_vld, skew_err;
  logic [8*NL-1:0] word_out;
  logic [7:0]    err_cnt;
  deskew_state_e state_dbg;

  always #5 byte_clock = ~byte_clock;

  csi_rx_lane_deskew #(
    .NUM_LANE   (NL),
    .MAX_SKEW   (MS),
    .FIFO_DEPTH (FD)
  ) dut (
    .byte_clock      (byte_clock),
    .reset           (reset),
    .enable          (enable),
    .active_lanes    (active_lanes),
    .byte_in         (byte_in),
    .byte_vld        (byte_vld),
    .packet_done     (packet_done),
    .wait_for_sync   (wait_for_sync),
    .packet_done_out (packet_done_out),
    .word_out        (word_out),
    .word_vld        (word_vld),
    .skew_err        (skew_err),
    .err_cnt         (err_cnt),
    .state_dbg       (state_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  lane_q [NL][$];
  bit          m_stream, m_vld, m_err, m_pdo;
  bit          m_arr [NL];
  int          m_n, m_first, m_cyc, m_cnt;
  logic [31:0] m_word;
  logic [7:0]  lane_ctr [NL];
  int          tb_step, first_vld_step;
  logic [31:0] first_word;

  int pk_off [NL];
  int pk_len, pk_pd_at, pk_stall_lane, pk_stall_at, pk_stall_len, pk_al_change_at, pk_noise_from;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (step %0d)", tag, obs, exp, tb_step);
    end
  endtask

  function automatic int lanes_of(input logic [2:0] a);
    if (a == 3'd1 || a == 3'd2 || a == 3'd4) return int'(a);
    return 1;
  endfunction

  task automatic model_flush();
    for (int i = 0; i < NL; i++) begin
      lane_q[i].delete();
      m_arr[i] = 1'b0;
    end
    m_first = -1;
  endtask

  task automatic model_reset();
    model_flush();
    m_stream = 1'b0; m_vld = 1'b0; m_err = 1'b0; m_pdo = 1'b0;
    m_word = '0; m_cnt = 0; m_n = 1;
    exp_q.delete();
  endtask

  // One byte-clock of the lane rules, using the inputs presented this cycle.
  task automatic model_step();
    int n;
    bit all_in, any_in, pop, ovf;
    m_pdo = packet_done && enable;
    m_vld = 1'b0;
    m_err = 1'b0;
    if (!enable) begin
      m_stream = 1'b0;
      model_flush();
    end else if (!m_stream) begin
      n = lanes_of(active_lanes);
      all_in = 1'b1;
      any_in = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (byte_vld[i]) begin
          lane_q[i].push_back(byte_in[8*i +: 8]);
          m_arr[i] = 1'b1;
        end
        all_in &= m_arr[i];
        any_in |= m_arr[i];
      end
      if (all_in) begin
        m_stream = 1'b1;
        m_n = n;
        for (int i = 0; i < NL; i++) m_arr[i] = 1'b0;
        m_first = -1;
      end else if (m_first >= 0 && (m_cyc - m_first) == MS) begin
        m_err = 1'b1;
        model_flush();
      end else if (any_in && m_first < 0) begin
        m_first = m_cyc;
      end
    end else begin
      pop = 1'b1;
      ovf = 1'b0;
      for (int i = 0; i < m_n; i++) begin
        if (lane_q[i].size() == 0) pop = 1'b0;
        if (byte_vld[i] && lane_q[i].size() == FD) ovf = 1'b1;
      end
      if (pop) begin
        m_vld = 1'b1;
        m_word = '0;
        for (int i = 0; i < m_n; i++) m_word[8*i +: 8] = lane_q[i].pop_front();
        exp_q.push_back(m_word);
      end
      for (int i = 0; i < m_n; i++) begin
        if (byte_vld[i]) lane_q[i].push_back(byte_in[8*i +: 8]);
      end
      if (ovf || packet_done) begin
        m_err = ovf;
        m_stream = 1'b0;
        model_flush();
      end
    end
    if (m_err && m_cnt < 255) m_cnt++;
    m_cyc++;
  endtask

  task automatic compare_outputs();
    check_eq("word_vld", 32'(word_vld), 32'(m_vld));
    check_eq("word_out", word_out, m_word);
    check_eq("wait_for_sync", 32'(wait_for_sync), 32'(!m_stream));
    check_eq("state_dbg", 32'(state_dbg == STREAM), 32'(m_stream));
    check_eq("skew_err", 32'(skew_err), 32'(m_err));
    check_eq("err_cnt", 32'(err_cnt), 32'(m_cnt));
    check_eq("packet_done_out", 32'(packet_done_out), 32'(m_pdo));
    if (word_vld) begin
      if (first_vld_step < 0) begin
        first_vld_step = tb_step;
        first_word = word_out;
      end
      check_eq("sb_word_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("sb_word", word_out, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [NL-1:0] v, input logic p);
    @(negedge byte_clock);
    byte_vld = v;
    packet_done = p;
    for (int i = 0; i < NL; i++) begin
      byte_in[8*i +: 8] = v[i] ? lane_ctr[i] : 8'($urandom);
      if (v[i]) lane_ctr[i] = lane_ctr[i] + 8'd1;
    end
    model_step();
    @(posedge byte_clock);
    #1;
    compare_outputs();
    tb_step++;
  endtask

  task automatic new_lanes(input logic [2:0] al);
    enable = 1'b0;
    active_lanes = al;
    step('0, 1'b0);
    enable = 1'b1;
  endtask

  task automatic clear_packet();
    for (int i = 0; i < NL; i++) pk_off[i] = 0;
    pk_len = 8; pk_pd_at = -1; pk_stall_lane = -1; pk_stall_at = 0;
    pk_stall_len = 0; pk_al_change_at = -1; pk_noise_from = NL;
  endtask

  task automatic run_packet();
    int span;
    logic [NL-1:0] v;
    span = pk_pd_at + 1;
    for (int i = 0; i < NL; i++) if (pk_off[i] + pk_len > span) span = pk_off[i] + pk_len;
    for (int c = 0; c < span; c++) begin
      for (int i = 0; i < NL; i++) begin
        v[i] = (c >= pk_off[i]) && (c < pk_off[i] + pk_len) &&
               !(i == pk_stall_lane && c >= pk_stall_at && c < pk_stall_at + pk_stall_len);
        if (i >= pk_noise_from) v[i] = 1'($urandom);
      end
      if (c == pk_al_change_at && m_stream) active_lanes = 3'($urandom_range(0, 7));
      step(v, c == pk_pd_at);
    end
    repeat (3) step('0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int t1_start, r;
    reset = 1'b1; enable = 1'b0; active_lanes = 3'd2;
    byte_in = '0; byte_vld = '0; packet_done = 1'b0;
    tb_step = 0; first_vld_step = -1; first_word = '0; m_cyc = 0;
    for (int i = 0; i < NL; i++) lane_ctr[i] = 8'hB8;
    model_reset();
    #1;
    check_eq("reset_wait_for_sync", 32'(wait_for_sync), 32'd1);
    check_eq("reset_word_vld", 32'(word_vld), 32'd0);
    check_eq("reset_word_out", word_out, 32'd0);
    check_eq("reset_err_cnt", 32'(err_cnt), 32'd0);
    repeat (2) @(negedge byte_clock);
    reset = 1'b0;

    // Two lanes, lane1 two cycles late, 0xB8 first bytes then counting.
    new_lanes(3'd2);
    clear_packet();
    pk_off[1] = 2; pk_len = 12; pk_pd_at = 15;
    first_vld_step = -1;
    t1_start = tb_step;
    run_packet();
    check_eq("t1_first_word", first_word, 32'h0000B8B8);
    check_eq("t1_latency", 32'(first_vld_step + 1 - (t1_start + 2)), 32'd2);

    // Lane1 five cycles behind lane0: skew timeout.
    new_lanes(3'd2);
    clear_packet();
    pk_off[1] = 5; pk_len = 1;
    run_packet();
    check_eq("t2_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("t2_wait_for_sync", 32'(wait_for_sync), 32'd1);

    // Two active lanes, lanes 2/3 toggling valid.
    new_lanes(3'd2);
    clear_packet();
    pk_off[0] = 1; pk_len = 10; pk_pd_at = 13; pk_noise_from = 2;
    run_packet();

    // packet_done in mid-stream with a pop in the same cycle.
    new_lanes(3'd2);
    clear_packet();
    pk_off[1] = 1; pk_len = 14; pk_pd_at = 7;
    run_packet();

    // Lane1 stalls long enough for lane0's FIFO to overflow.
    new_lanes(3'd2);
    clear_packet();
    pk_len = 30; pk_stall_lane = 1; pk_stall_at = 4; pk_stall_len = 10;
    run_packet();

    // Asynchronous reset in the middle of a 4-lane stream.
    new_lanes(3'd4);
    for (int c = 0; c < 6; c++) step('1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_wait_for_sync", 32'(wait_for_sync), 32'd1);
    check_eq("t6_word_vld", 32'(word_vld), 32'd0);
    check_eq("t6_word_out", word_out, 32'd0);
    check_eq("t6_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("t6_skew_err", 32'(skew_err), 32'd0);
    model_reset();
    #2 reset = 1'b0;
    new_lanes(3'd4);
    clear_packet();
    pk_off[2] = 3; pk_len = 10; pk_pd_at = 14;
    run_packet();

    // Randomised packets: lane counts, skews, stalls, early packet_done.
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      clear_packet();
      if (r < 3)      active_lanes = 3'd1;
      else if (r < 6) active_lanes = 3'd2;
      else if (r < 9) active_lanes = 3'd4;
      else            active_lanes = 3'($urandom_range(0, 7));
      new_lanes(active_lanes);
      for (int i = 0; i < NL; i++) pk_off[i] = $urandom_range(0, MS + 1);
      pk_len = $urandom_range(3, 16);
      pk_pd_at = $urandom_range(4, MS + pk_len + 3);
      if ($urandom_range(0, 3) == 0) pk_stall_lane = $urandom_range(0, NL - 1);
      pk_stall_at = $urandom_range(0, 8);
      pk_stall_len = $urandom_range(1, 12);
      if ($urandom_range(0, 3) == 0) pk_al_change_at = $urandom_range(2, 10);
      if ($urandom_range(0, 1) == 1) pk_noise_from = lanes_of(active_lanes);
      run_packet();
    end

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
